// File: rtl/ahb_lite_master_arbiter.sv
// AHB-Lite master front end: arbitrates N requesters onto one master port.
// SINGLE transfers only, with overlapped address and data phases.
module ahb_lite_master_arbiter #(
    parameter int N_PORTS  = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PORTS-1:0]         req_valid,
    output logic [N_PORTS-1:0]         req_ready,
    input  logic [N_PORTS*ADDR_W-1:0]  req_addr,
    input  logic [N_PORTS-1:0]         req_write,
    input  logic [N_PORTS*3-1:0]       req_size,
    input  logic [N_PORTS*4-1:0]       req_prot,
    input  logic [N_PORTS*DATA_W-1:0]  req_wdata,
    output logic [N_PORTS-1:0]         rsp_valid,
    output logic [N_PORTS*DATA_W-1:0]  rsp_rdata,
    output logic [N_PORTS-1:0]         rsp_err,
    output logic [ADDR_W-1:0]          HADDR,
    output logic [2:0]                 HBURST,
    output logic                       HMASTLOCK,
    output logic [3:0]                 HPROT,
    output logic [2:0]                 HSIZE,
    output logic [1:0]                 HTRANS,
    output logic [DATA_W-1:0]          HWDATA,
    output logic                       HWRITE,
    input  logic [DATA_W-1:0]          HRDATA,
    input  logic                       HREADY,
    input  logic                       HRESP
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic              as_valid;
    logic [PW-1:0]     as_owner;
    logic [ADDR_W-1:0] as_addr;
    logic              as_write;
    logic [2:0]        as_size;
    logic [3:0]        as_prot;
    logic [DATA_W-1:0] as_wdata;

    logic              ds_valid;
    logic [PW-1:0]     ds_owner;
    logic              ds_write;
    logic [DATA_W-1:0] ds_wdata;

    logic              cancel;
    logic [PW-1:0]     rr_ptr;

    logic              adv;
    logic              slot_free;
    logic              found;
    logic              acc;
    logic [PW-1:0]     win;
    int                idx;

    assign adv       = HREADY && !HRESP && !cancel;
    assign slot_free = !as_valid || adv;
    assign acc       = found && slot_free;

    assign HADDR     = as_addr;
    assign HWRITE    = as_write;
    assign HSIZE     = as_size;
    assign HPROT     = as_prot;
    assign HTRANS    = (as_valid && !cancel) ? 2'b10 : 2'b00;
    assign HWDATA    = ds_wdata;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;

    // Pick the winning requester and raise its ready when the slot can take it.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        idx       = 0;
        req_ready = '0;
        if (ARB_MODE == 0) begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    found = 1'b1;
                    win   = PW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N_PORTS; k++) begin
                idx = (int'(rr_ptr) + k) % N_PORTS;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    win   = PW'(idx);
                end
            end
        end
        if (acc) begin
            req_ready[win] = 1'b1;
        end
    end

    // Address slot: reload on phase advance, or fill when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            as_valid <= 1'b0;
            as_owner <= '0;
            as_addr  <= '0;
            as_write <= 1'b0;
            as_size  <= '0;
            as_prot  <= '0;
            as_wdata <= '0;
            rr_ptr   <= PW'(N_PORTS - 1);
        end else if (slot_free) begin
            as_valid <= acc;
            if (acc) begin
                as_owner <= win;
                as_addr  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
                as_write <= req_write[win];
                as_size  <= req_size[int'(win)*3 +: 3];
                as_prot  <= req_prot[int'(win)*4 +: 4];
                as_wdata <= req_wdata[int'(win)*DATA_W +: DATA_W];
                rr_ptr   <= win;
            end
        end
    end

    // Data slot and cancel flag: advance, hold on wait, drop after an error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_valid <= 1'b0;
            ds_owner <= '0;
            ds_write <= 1'b0;
            ds_wdata <= '0;
            cancel   <= 1'b0;
        end else begin
            cancel <= HRESP && !HREADY;
            if (adv) begin
                ds_valid <= as_valid;
                ds_owner <= as_owner;
                ds_write <= as_write;
                ds_wdata <= as_wdata;
            end else if (HREADY) begin
                ds_valid <= 1'b0;
            end
        end
    end

    // Per-port response pulse when the data phase completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= '0;
        end else begin
            rsp_valid <= '0;
            if (HREADY && ds_valid) begin
                rsp_valid[ds_owner] <= 1'b1;
                rsp_err[ds_owner]   <= HRESP;
                rsp_rdata[int'(ds_owner)*DATA_W +: DATA_W] <=
                    ds_write ? '0 : HRDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Randomised bench: two arbiters (fixed, round-robin) against a
// transaction-queue model with a random wait/error slave.
module tb_ahb_lite_master_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        int unsigned    port;
        logic [AW-1:0]  addr;
        logic           wr;
        logic [2:0]     size;
        logic [3:0]     prot;
        logic [DW-1:0]  wdata;
        bit             dp;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [NP-1:0]    req_valid [2];
    logic [NP-1:0]    req_ready [2];
    logic [NP*AW-1:0] req_addr  [2];
    logic [NP-1:0]    req_write [2];
    logic [NP*3-1:0]  req_size  [2];
    logic [NP*4-1:0]  req_prot  [2];
    logic [NP*DW-1:0] req_wdata [2];
    logic [NP-1:0]    rsp_valid [2];
    logic [NP*DW-1:0] rsp_rdata [2];
    logic [NP-1:0]    rsp_err   [2];
    logic [AW-1:0]    haddr     [2];
    logic [2:0]       hburst    [2];
    logic             hmastlock [2];
    logic [3:0]       hprot     [2];
    logic [2:0]       hsize     [2];
    logic [1:0]       htrans    [2];
    logic [DW-1:0]    hwdata    [2];
    logic             hwrite    [2];
    logic [DW-1:0]    hrdata    [2];
    logic             hready    [2];
    logic             hresp     [2];

    txn_t          pipe [2][$];
    txn_t          pend [2][NP];
    bit            pendv [2][NP];
    bit            cancel_m [2];
    int            rr_m [2];
    bit            rspv_m [2];
    int            rspp_m [2];
    logic [DW-1:0] rspd_m [2];
    bit            rspe_m [2];
    bit            errph [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ahb_lite_master_arbiter #(
        .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)
    ) u_fix (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_prot(req_prot[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .HADDR(haddr[0]), .HBURST(hburst[0]), .HMASTLOCK(hmastlock[0]),
        .HPROT(hprot[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]),
        .HWDATA(hwdata[0]), .HWRITE(hwrite[0]), .HRDATA(hrdata[0]),
        .HREADY(hready[0]), .HRESP(hresp[0])
    );

    ahb_lite_master_arbiter #(
        .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)
    ) u_rr (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_prot(req_prot[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .HADDR(haddr[1]), .HBURST(hburst[1]), .HMASTLOCK(hmastlock[1]),
        .HPROT(hprot[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]),
        .HWDATA(hwdata[1]), .HWRITE(hwrite[1]), .HRDATA(hrdata[1]),
        .HREADY(hready[1]), .HRESP(hresp[1])
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Fixed mode: lowest index. Round-robin: first requester after last winner.
    function automatic int pick(int d, logic [NP-1:0] v);
        int i;
        for (int k = 1; k <= NP; k++) begin
            i = (d == 0) ? k - 1 : (rr_m[d] + k) % NP;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit has_data(int d);
        return pipe[d].size() > 0 && pipe[d][0].dp;
    endfunction

    task automatic clear_model(int d);
        pipe[d].delete();
        cancel_m[d] = 1'b0;
        rr_m[d]     = NP - 1;
        rspv_m[d]   = 1'b0;
        errph[d]    = 1'b0;
        for (int p = 0; p < NP; p++) pendv[d][p] = 1'b0;
        req_valid[d] = '0;
        req_addr[d]  = '0;
        req_write[d] = '0;
        req_size[d]  = '0;
        req_prot[d]  = '0;
        req_wdata[d] = '0;
        hrdata[d]    = '0;
        hready[d]    = 1'b1;
        hresp[d]     = 1'b0;
    endtask

    task automatic drive(int d, int rate);
        int r;
        for (int p = 0; p < NP; p++) begin
            if (!pendv[d][p] && $urandom_range(99) < rate) begin
                pend[d][p].port  = p;
                pend[d][p].addr  = $urandom & ~32'h3;
                pend[d][p].wr    = 1'($urandom_range(1));
                pend[d][p].size  = 3'($urandom_range(2));
                pend[d][p].prot  = 4'($urandom);
                pend[d][p].wdata = $urandom;
                pend[d][p].dp    = 1'b0;
                pendv[d][p]      = 1'b1;
            end
            req_valid[d][p]             = pendv[d][p];
            req_write[d][p]             = pend[d][p].wr;
            req_addr[d][p*AW +: AW]     = pend[d][p].addr;
            req_size[d][p*3 +: 3]       = pend[d][p].size;
            req_prot[d][p*4 +: 4]       = pend[d][p].prot;
            req_wdata[d][p*DW +: DW]    = pend[d][p].wdata;
        end
        hrdata[d] = $urandom;
        if (errph[d]) begin
            hready[d] = 1'b1;
            hresp[d]  = 1'b1;
        end else if (has_data(d)) begin
            r = $urandom_range(99);
            hready[d] = (r < 60);
            hresp[d]  = (r >= 85);
        end else begin
            hready[d] = 1'b1;
            hresp[d]  = 1'b0;
        end
    endtask

    task automatic step(int d);
        int n;
        bit hd, ha, adv, fr;
        int w;
        logic [NP-1:0] rdy, rv;
        txn_t t;
        string u;
        u   = $sformatf("u%0d.", d);
        n   = pipe[d].size();
        hd  = n > 0 && pipe[d][0].dp;
        ha  = n > 0 && !pipe[d][n-1].dp;
        adv = hready[d] && !hresp[d] && !cancel_m[d];
        fr  = !ha || adv;
        w   = fr ? pick(d, req_valid[d]) : -1;
        rdy = '0;
        rv  = '0;
        if (w >= 0) rdy[w] = 1'b1;
        chk({u, "ready"}, 64'(req_ready[d]), 64'(rdy));
        chk({u, "htrans"}, 64'(htrans[d]),
            64'((ha && !cancel_m[d]) ? 2'b10 : 2'b00));
        if (ha && !cancel_m[d]) begin
            t = pipe[d][n-1];
            chk({u, "aphase"},
                64'({haddr[d], hwrite[d], hsize[d], hprot[d]}),
                64'({t.addr, t.wr, t.size, t.prot}));
        end
        chk({u, "const"}, 64'({hburst[d], hmastlock[d]}), 64'(0));
        if (hd && pipe[d][0].wr)
            chk({u, "hwdata"}, 64'(hwdata[d]), 64'(pipe[d][0].wdata));
        if (rspv_m[d]) rv[rspp_m[d]] = 1'b1;
        chk({u, "rsp_valid"}, 64'(rsp_valid[d]), 64'(rv));
        if (rspv_m[d]) begin
            chk({u, "rdata"}, 64'(rsp_rdata[d][rspp_m[d]*DW +: DW]),
                64'(rspd_m[d]));
            chk({u, "rerr"}, 64'(rsp_err[d][rspp_m[d]]), 64'(rspe_m[d]));
        end
        rspv_m[d] = 1'b0;
        if (hready[d] && hd) begin
            t = pipe[d].pop_front();
            rspv_m[d] = 1'b1;
            rspp_m[d] = t.port;
            rspd_m[d] = t.wr ? '0 : hrdata[d];
            rspe_m[d] = hresp[d];
        end
        if (adv && ha) begin
            t = pipe[d].pop_back();
            t.dp = 1'b1;
            pipe[d].push_back(t);
        end
        if (w >= 0) begin
            t = pend[d][w];
            t.dp = 1'b0;
            pipe[d].push_back(t);
            rr_m[d]     = w;
            pendv[d][w] = 1'b0;
        end
        cancel_m[d] = hresp[d] && !hready[d];
        errph[d]    = hresp[d] && !hready[d];
    endtask

    task automatic chk_idle(string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("u%0d.%s_ahb", d, tag),
                64'({htrans[d], hwrite[d], hsize[d], hprot[d], haddr[d]}),
                64'(0));
            chk($sformatf("u%0d.%s_wd", d, tag), 64'(hwdata[d]), 64'(0));
            chk($sformatf("u%0d.%s_rsp", d, tag),
                64'({rsp_valid[d], rsp_err[d], |rsp_rdata[d]}), 64'(0));
        end
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        #1;
        chk_idle("mid_rst");
        for (int d = 0; d < 2; d++) clear_model(d);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) clear_model(d);
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1500 || cyc == 3200) do_reset();
            for (int d = 0; d < 2; d++) drive(d, cyc < 1500 ? 95 : 40);
            @(negedge clk);
            for (int d = 0; d < 2; d++) step(d);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master_arbiter.md
Name: ahb_lite_master_arbiter

Overview:
- Parametrised AHB-Lite master front end between N internal requesters (instruction fetch, data load/store, debug) and the single AHB-Lite master port of the core.
- Arbitrates requests and issues SINGLE transfers with full address/data phase pipelining.
- Handles wait states and the two-cycle ERROR response, and returns per-port responses.
- Replaces the per-stage direct driving of HADDR/HTRANS in the pipeline core.

Parameters:
- N_PORTS, 2, number of requester ports; port 0 = fetch, port 1 = data.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- req_valid  input  N_PORTS  request present per port
- req_ready  output  N_PORTS  request accepted this cycle (combinational)
- req_addr  input  N_PORTS*ADDR_W  per-port address
- req_write  input  N_PORTS  1 = write
- req_size  input  N_PORTS*3  HSIZE encoding per port
- req_prot  input  N_PORTS*4  HPROT per port
- req_wdata  input  N_PORTS*DATA_W  lane-aligned write data
- rsp_valid  output  N_PORTS  one-cycle response pulse per port
- rsp_rdata  output  N_PORTS*DATA_W  read data per port
- rsp_err  output  N_PORTS  transfer ended in ERROR
- HADDR  output  ADDR_W  AHB address
- HBURST  output  3  constant 3'b000 (SINGLE)
- HMASTLOCK  output  1  constant 0
- HPROT  output  4  protection of current address phase
- HSIZE  output  3  transfer size
- HTRANS  output  2  IDLE 2'b00 / NONSEQ 2'b10 only
- HWDATA  output  DATA_W  write data of current data phase
- HWRITE  output  1  transfer direction
- HRDATA  input  DATA_W  read data
- HREADY  input  1  transfer complete / phase advance
- HRESP  input  1  1 = ERROR

Behaviour:
- Reset (async, immediate): all AHB outputs 0 (HTRANS = IDLE); address slot, data slot and cancel flag cleared; RR pointer = N_PORTS-1; rsp_valid, rsp_rdata, rsp_err = 0. A transfer in flight at reset is abandoned and produces no response.
- State:
  - Address slot (AS): valid, owner, addr, write, size, prot, wdata. Drives HADDR/HWRITE/HSIZE/HPROT from registers.
  - HTRANS = NONSEQ when AS valid and cancel = 0, else IDLE.
  - Data slot (DS): valid, owner, write, wdata. HWDATA = DS wdata, held stable while HREADY = 0.
- Slot free (combinational): AS empty, or (HREADY = 1 and HRESP = 0 and cancel = 0).
- Arbitration:
  - When slot free, the winner among req_valid gets req_ready = 1; at most one req_ready bit is high per cycle.
  - Fixed mode: lowest asserted index wins.
  - RR mode: search starts at pointer+1 modulo N_PORTS; pointer updates to the winner only on acceptance.
- Phase advance, on a clock edge with HREADY = 1, HRESP = 0, cancel = 0:
  - DS loads AS contents (DS valid = AS valid).
  - AS loads the accepted request, or becomes empty if none was accepted.
- Wait state (HREADY = 0, HRESP = 0): AS, DS and all AHB outputs hold; no acceptance.
- Response:
  - On an edge where HREADY = 1 and DS is valid, the next cycle has rsp_valid[DS owner] = 1 for exactly one cycle.
  - rsp_rdata[owner] = HRDATA for reads, 0 for writes.
  - rsp_err[owner] = HRESP.
  - Other ports' rsp outputs are not updated.
- Latency: request accepted in cycle C, NONSEQ in C+1, data phase in C+2, rsp_valid in C+3 with zero wait states; each wait state adds one cycle. Sustained throughput is 1 transfer/cycle.
- ERROR handling:
  - Error cycle 1 (HRESP = 1, HREADY = 0): the cancel flag sets at the edge ending it, so HTRANS = IDLE in error cycle 2. AS contents are retained and nothing is accepted.
  - Error cycle 2 (HRESP = 1, HREADY = 1): the error response is issued, DS clears, cancel clears, AS is not moved into DS.
  - The retained AS transfer is driven NONSEQ again in the following cycle.
- Simultaneous events:
  - A request arriving in the same cycle as an AS completion is accepted, so back-to-back transfers have no bubble.
  - A response and a new acceptance for the same port may coincide.
- Responses for a given port arrive in acceptance order, since there is a single pipeline.

Test Plan:
- Port0 read 0x100, zero wait, HRDATA = 0xDEADBEEF -> req_ready[0] in C; HTRANS = NONSEQ, HADDR = 0x100 in C+1; rsp_valid[0] = 1 with rsp_rdata[0] = 0xDEADBEEF in C+3.
- Port1 writes 0x200/0x11 then 0x204/0x22 back-to-back -> HADDR = 0x204 in the same cycle as HWDATA = 0x11; HWDATA = 0x22 next cycle; two rsp_valid[1] pulses with rsp_err = 0.
- HREADY low for 2 cycles during the 0x11 data phase -> HADDR = 0x204 and HWDATA = 0x11 held 3 cycles; responses delayed by 2.
- Both ports requesting continuously for 6 grants -> ARB_MODE = 0 grants 0,0,0,0,0,0; ARB_MODE = 1 grants 0,1,0,1,0,1.
- Read 0x300 gets HRESP = 1 for two cycles while 0x304 is in AS -> HTRANS = IDLE in error cycle 2; rsp_err[0] = 1; 0x304 driven NONSEQ the next cycle and completes normally.
- Reset asserted mid data phase -> HTRANS = IDLE and all outputs 0 immediately; no rsp_valid after release; a new request after release completes normally.
